// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver (8 data bits, LSB first, 1 stop bit).
// The rx input passes through a two-flop synchronizer. Each bit is the 2-of-3
// majority of the samples taken at oversample counts 7, 8 and 9. Received bytes
// go into a one-entry holding register that uses a valid/ready handshake.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit after the
// data bits. parity_error is tied to 0 when the macro is undefined.
module uart_rx #(
  parameter int unsigned CLOCK_DIVIDE = 326
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       is_receiving,
  output logic       frame_error,
  output logic       parity_error,
  output logic       overrun
);

  localparam logic [10:0] TickReload = 11'(CLOCK_DIVIDE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rxs;
  logic [10:0] tick_cnt;
  logic        tick;
  logic [3:0]  sample_cnt;
  logic        s7;
  logic        s8;
  logic        maj;
  logic        at_dec;
  logic        at_end;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        par_bad;
  logic        start_det;
  logic        deliver;

  // Two-flop synchronizer; it resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign start_det = (state == StIdle) && !rxs;
  assign tick      = (tick_cnt == 11'd0);

  // Oversample tick generator. A start edge realigns it so that the sample
  // points land at the centre of each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= 11'd0;
    end else if (start_det || tick) begin
      tick_cnt <= TickReload;
    end else begin
      tick_cnt <= tick_cnt - 11'd1;
    end
  end

  // The count-9 sample comes straight from rxs, so the vote is ready on the
  // decision tick itself.
  assign maj     = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign at_dec  = tick && (sample_cnt == 4'd9);
  assign at_end  = tick && (sample_cnt == 4'd15);
  assign deliver = (state == StStop) && at_dec && maj && !par_bad;

  assign is_receiving = (state != StIdle);

`ifndef UART_RX_PARITY_EN
  assign par_bad      = 1'b0;
  assign parity_error = 1'b0;
`endif

  // Frame FSM, bit sampling, error pulses and the holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      sample_cnt   <= 4'd0;
      s7           <= 1'b1;
      s8           <= 1'b1;
      bit_idx      <= 3'd0;
      shift        <= 8'h00;
      rx_byte      <= 8'h00;
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif

      if (tick) begin
        sample_cnt <= sample_cnt + 4'd1;
        if (sample_cnt == 4'd7) s7 <= rxs;
        if (sample_cnt == 4'd8) s8 <= rxs;
      end

      case (state)
        StIdle: begin
          if (!rxs) begin
            state      <= StStart;
            sample_cnt <= 4'd0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
`endif
          end
        end
        StStart: begin
          // A start bit that votes high was a glitch; drop it silently.
          if (at_dec && maj) begin
            state <= StIdle;
          end else if (at_end) begin
            state   <= StData;
            bit_idx <= 3'd0;
          end
        end
        StData: begin
          if (at_dec) shift <= {maj, shift[7:1]};
          if (at_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= StParity;
`else
              state <= StStop;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (at_dec) begin
            par_bad      <= (maj != ^shift);
            parity_error <= (maj != ^shift);
          end
          if (at_end) state <= StStop;
        end
`endif
        StStop: begin
          // Decide at mid-stop so that the next start edge can follow at once.
          if (at_dec) begin
            if (maj) begin
              state <= StIdle;
            end else begin
              frame_error <= 1'b1;
              state       <= StWaitHigh;
            end
          end
        end
        StWaitHigh: begin
          // Hold off until the line is released so that a break does not retrigger.
          if (rxs) state <= StIdle;
        end
        default: state <= StIdle;
      endcase

      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_byte  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with CLOCK_DIVIDE=4 (64 clk per bit).
module tb_uart_rx;

  localparam int BitClk = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       is_receiving;
  logic       frame_error;
  logic       parity_error;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  // Event counters kept by the monitor; tests compare deltas against snapshots.
  int         valid_cyc = 0;
  int         fe_cyc    = 0;
  int         pe_cyc    = 0;
  int         ov_cyc    = 0;
  logic [7:0] last_byte = 8'h00;

  int v0, f0, p0, o0;

  uart_rx #(.CLOCK_DIVIDE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .is_receiving (is_receiving),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Outputs are observed on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cyc <= valid_cyc + 1;
      last_byte <= rx_byte;
    end
    if (frame_error)  fe_cyc <= fe_cyc + 1;
    if (parity_error) pe_cyc <= pe_cyc + 1;
    if (overrun)      ov_cyc <= ov_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clk(BitClk);
  endtask

  task automatic snap();
    v0 = valid_cyc;
    f0 = fe_cyc;
    p0 = pe_cyc;
    o0 = ov_cyc;
  endtask

  // Start bit, data bits and (when enabled) the parity bit; par_flip corrupts the parity.
  task automatic send_head(input logic [7:0] d, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity not built in, flip ignored");
`endif
  endtask

  task automatic send_byte(input logic [7:0] d, input logic par_flip);
    send_head(d, par_flip);
    drive_bit(1'b1);
  endtask

  initial begin
    wait_clk(5);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_byte", 32'(rx_byte), 32'h00);
    check("rst_busy", 32'(is_receiving), 32'd0);
    check("rst_fe", 32'(frame_error), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    rst = 1'b0;
    wait_clk(10);

    // Clean 0xA5 frame with the consumer ready.
    snap();
    send_head(8'hA5, 1'b0);
    rx = 1'b1;
    wait_clk(20);
    check("a5_busy_early_stop", 32'(is_receiving), 32'd1);
    wait_clk(44);
    check("a5_idle_end_stop", 32'(is_receiving), 32'd0);
    wait_clk(20);
    check("a5_byte", 32'(last_byte), 32'hA5);
    check("a5_valid_cycles", 32'(valid_cyc - v0), 32'd1);
    check("a5_fe", 32'(fe_cyc - f0), 32'd0);
    check("a5_ov", 32'(ov_cyc - o0), 32'd0);
    check("a5_pe", 32'(pe_cyc - p0), 32'd0);

    // 20-clk glitch: detected, then rejected by the start-bit vote.
    snap();
    rx = 1'b0;
    wait_clk(10);
    check("glitch_detected", 32'(is_receiving), 32'd1);
    wait_clk(10);
    rx = 1'b1;
    wait_clk(100);
    check("glitch_idle", 32'(is_receiving), 32'd0);
    check("glitch_no_valid", 32'(valid_cyc - v0), 32'd0);
    check("glitch_no_fe", 32'(fe_cyc - f0), 32'd0);

    // 0x3C with a low stop bit, then the line held low for three more bits.
    snap();
    send_head(8'h3C, 1'b0);
    rx = 1'b0;
    wait_clk(BitClk * 4);
    check("fe_pulse", 32'(fe_cyc - f0), 32'd1);
    check("fe_no_valid", 32'(valid_cyc - v0), 32'd0);
    check("fe_wait_high", 32'(is_receiving), 32'd1);
    rx = 1'b1;
    wait_clk(10);
    check("fe_released", 32'(is_receiving), 32'd0);
    wait_clk(BitClk);

    // Overrun: the consumer stalls across two back-to-back frames.
    rx_ready = 1'b0;
    snap();
    send_byte(8'h11, 1'b0);
    check("ov_first_valid", 32'(rx_valid), 32'd1);
    check("ov_first_byte", 32'(rx_byte), 32'h11);
    send_byte(8'h22, 1'b0);
    wait_clk(20);
    check("ov_byte_kept", 32'(rx_byte), 32'h11);
    check("ov_pulse", 32'(ov_cyc - o0), 32'd1);
    check("ov_still_valid", 32'(rx_valid), 32'd1);
    check("ov_no_fe", 32'(fe_cyc - f0), 32'd0);
    rx_ready = 1'b1;
    wait_clk(1);
    check("ov_drained", 32'(rx_valid), 32'd0);
    wait_clk(20);

    // Reset during data bit 4 of 0xFF, then a clean 0x5A.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    wait_clk(30);
    rst = 1'b1;
    wait_clk(1);
    check("mid_rst_busy", 32'(is_receiving), 32'd0);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_byte", 32'(rx_byte), 32'h00);
    check("mid_rst_fe", 32'(frame_error), 32'd0);
    check("mid_rst_ov", 32'(overrun), 32'd0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(BitClk * 5);
    snap();
    send_byte(8'h5A, 1'b0);
    wait_clk(20);
    check("post_rst_byte", 32'(last_byte), 32'h5A);
    check("post_rst_valid_cycles", 32'(valid_cyc - v0), 32'd1);
    check("post_rst_fe", 32'(fe_cyc - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 0x07 with a wrong parity bit, then with the correct one.
    snap();
    send_byte(8'h07, 1'b1);
    wait_clk(20);
    check("par_bad_pulse", 32'(pe_cyc - p0), 32'd1);
    check("par_bad_no_valid", 32'(valid_cyc - v0), 32'd0);
    snap();
    send_byte(8'h07, 1'b0);
    wait_clk(20);
    check("par_ok_no_pe", 32'(pe_cyc - p0), 32'd0);
    check("par_ok_valid_cycles", 32'(valid_cyc - v0), 32'd1);
    check("par_ok_byte", 32'(last_byte), 32'h07);
`else
    check("no_parity_pulses", 32'(pe_cyc), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
